// File: rtl/filter_menu_lcd.sv
// filter_menu_lcd: pushbutton-driven menu that browses N_MODES filter modes,
// commits the browsed mode to filter_mode, and rewrites the browsed mode's
// name on an Avalon-MM LCD controller after every browse or commit.
// Optional build macro: BTN_DEBOUNCE_EN (2-flop synchroniser + stable-sample
// counter on every button; when undefined the raw levels feed edge detection).
module filter_menu_lcd #(
   parameter int unsigned N_MODES         = 5,
   parameter int unsigned MSG_LEN         = 16,
   parameter int unsigned WRAP            = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left,
   input  logic       right,
   input  logic       select,
   output logic [2:0] filter_mode,
   output logic [2:0] cursor,
   output logic       busy,
   output logic       address,
   output logic       chipselect,
   output logic       byteenable,
   output logic       read,
   output logic       write,
   input  logic       waitrequest,
   input  logic [7:0] readdata,
   input  logic [1:0] response,
   output logic [7:0] writedata
);

   localparam logic [2:0] LAST_MODE = 3'(N_MODES - 1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_GAP = 2'd2} state_t;

   // Name ROM: left-justified, NUL padded 16-character names.
   function automatic logic [7:0] name_char(input logic [2:0] m, input logic [3:0] p);
      logic [127:0] s;
      case (m)
         3'd0:    s = {"No Filter",  56'h0};
         3'd1:    s = {"Desaturate", 48'h0};
         3'd2:    s = {"Shift",      88'h0};
         3'd3:    s = {"Blur",       96'h0};
         3'd4:    s = {"Edge",       96'h0};
         3'd5:    s = {"Mode 5",     80'h0};
         3'd6:    s = {"Mode 6",     80'h0};
         3'd7:    s = {"Mode 7",     80'h0};
         default: s = 128'h0;
      endcase
      return s[8*(15 - int'(p)) +: 8];
   endfunction

   // Characters actually sent: up to the first NUL, capped at MSG_LEN.
   function automatic logic [4:0] name_len(input logic [2:0] m);
      logic [4:0] n;
      logic       stop;
      n    = 5'd0;
      stop = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!stop && (i < int'(MSG_LEN)) && (name_char(m, 4'(i)) != 8'h00)) begin
            n = n + 5'd1;
         end else begin
            stop = 1'b1;
         end
      end
      return n;
   endfunction

   logic [2:0] btn_raw_s;
   logic [2:0] btn_lvl_s;
   logic [2:0] btn_q;
   logic [2:0] ev_s;

   assign btn_raw_s = {select, right, left};

`ifdef BTN_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   for (genvar b = 0; b < 3; b++) begin : g_deb
      logic          s1_q;
      logic          s2_q;
      logic          filt_q;
      logic [CW-1:0] cnt_q;

      // Synchronise the button and accept a new level only after it is stable.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            s1_q <= btn_raw_s[b];
            s2_q <= s1_q;
            if (s2_q == filt_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               filt_q <= s2_q;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end

      assign btn_lvl_s[b] = filt_q;
   end
`else
   logic unused_debounce_s;
   assign unused_debounce_s = ^DEBOUNCE_CYCLES;
   assign btn_lvl_s         = btn_raw_s;
`endif

   logic unused_inputs_s;
   assign unused_inputs_s = ^{readdata, response};

   assign ev_s = btn_lvl_s & ~btn_q;

   logic [2:0] cursor_q, cursor_d;
   logic [2:0] filter_mode_q, filter_mode_d;
   logic       dirty_q, dirty_d;
   logic       set_dirty_s;

   state_t     state_q;
   logic [2:0] snap_q;
   logic [4:0] index_q;
   logic       done_q;
   logic       busy_q;
   logic       write_q;
   logic       address_q;
   logic [7:0] writedata_q;

   // Cursor movement, commit and the dirty request that triggers a rewrite.
   always_comb begin
      cursor_d      = cursor_q;
      filter_mode_d = filter_mode_q;
      if (ev_s[1] && !ev_s[0]) begin
         if (cursor_q == LAST_MODE) begin
            if (WRAP != 32'd0) begin
               cursor_d = 3'd0;
            end else begin
               cursor_d = cursor_q;
            end
         end else begin
            cursor_d = cursor_q + 3'd1;
         end
      end else if (ev_s[0] && !ev_s[1]) begin
         if (cursor_q == 3'd0) begin
            if (WRAP != 32'd0) begin
               cursor_d = LAST_MODE;
            end else begin
               cursor_d = cursor_q;
            end
         end else begin
            cursor_d = cursor_q - 3'd1;
         end
      end else begin
         cursor_d = cursor_q;
      end
      if (ev_s[2]) begin
         filter_mode_d = cursor_q;
      end else begin
         filter_mode_d = filter_mode_q;
      end
      set_dirty_s = (cursor_d != cursor_q) || ev_s[2];
      // A new request wins over the clear that accompanies starting a sequence.
      if (set_dirty_s) begin
         dirty_d = 1'b1;
      end else if ((state_q == ST_IDLE) && dirty_q) begin
         dirty_d = 1'b0;
      end else begin
         dirty_d = dirty_q;
      end
   end

   // Button history, cursor, committed mode and dirty flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_q         <= 3'b000;
         cursor_q      <= 3'd0;
         filter_mode_q <= 3'd0;
         dirty_q       <= 1'b1;
      end else begin
         btn_q         <= btn_lvl_s;
         cursor_q      <= cursor_d;
         filter_mode_q <= filter_mode_d;
         dirty_q       <= dirty_d;
      end
   end

   logic [4:0] last_idx_s;
   logic       item_addr_s;
   logic [7:0] item_data_s;

   // Item at index_q: 0 = clear, 1..len = name characters, then optional '*'.
   always_comb begin
      last_idx_s = name_len(snap_q) + {4'd0, (snap_q == filter_mode_q)};
      if (index_q == 5'd0) begin
         item_addr_s = 1'b0;
         item_data_s = 8'h01;
      end else if (index_q <= name_len(snap_q)) begin
         item_addr_s = 1'b1;
         item_data_s = name_char(snap_q, 4'(index_q - 5'd1));
      end else begin
         item_addr_s = 1'b1;
         item_data_s = 8'h2A;
      end
   end

   // LCD write sequencer with registered Avalon outputs and busy flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         snap_q      <= 3'd0;
         index_q     <= 5'd0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         write_q     <= 1'b0;
         address_q   <= 1'b0;
         writedata_q <= 8'h00;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (dirty_q) begin
                  state_q     <= ST_ISSUE;
                  snap_q      <= cursor_q;
                  index_q     <= 5'd0;
                  busy_q      <= 1'b1;
                  write_q     <= 1'b1;
                  address_q   <= 1'b0;
                  writedata_q <= 8'h01;
               end else begin
                  state_q     <= ST_IDLE;
                  busy_q      <= dirty_d;
                  write_q     <= 1'b0;
                  address_q   <= 1'b0;
                  writedata_q <= 8'h00;
               end
            end
            ST_ISSUE: begin
               busy_q <= 1'b1;
               if (!waitrequest) begin
                  state_q     <= ST_GAP;
                  done_q      <= (index_q == last_idx_s) || dirty_q;
                  index_q     <= index_q + 5'd1;
                  write_q     <= 1'b0;
                  address_q   <= 1'b0;
                  writedata_q <= 8'h00;
               end else begin
                  state_q <= ST_ISSUE;
               end
            end
            ST_GAP: begin
               if (done_q) begin
                  state_q <= ST_IDLE;
                  busy_q  <= dirty_d;
               end else begin
                  state_q     <= ST_ISSUE;
                  busy_q      <= 1'b1;
                  write_q     <= 1'b1;
                  address_q   <= item_addr_s;
                  writedata_q <= item_data_s;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b1;
               write_q <= 1'b0;
            end
         endcase
      end
   end

   assign filter_mode = filter_mode_q;
   assign cursor      = cursor_q;
   assign busy        = busy_q;
   assign address     = address_q;
   assign chipselect  = write_q;
   assign write       = write_q;
   assign writedata   = writedata_q;
   assign byteenable  = 1'b1;
   assign read        = 1'b0;

endmodule

// File: doc/filter_menu_lcd.md
Name: filter_menu_lcd

Overview:
- Parametrised successor to the single-purpose filter selector: a button-driven menu of N_MODES modes.
- Left/right browse a cursor; select commits the browsed mode to `filter_mode`.
- The browsed mode's name is written to the LCD_Controller over Avalon-MM, and the display is rewritten on every browse or commit.
- Sits between the board pushbuttons/LCD controller and the image-filter pipeline.

Parameters:
- N_MODES, 5, number of selectable modes (2..8).
- MSG_LEN, 16, max characters written per name (1..16).
- WRAP, 1, 1 = cursor wraps at the ends; 0 = cursor saturates at 0 and N_MODES-1.
- DEBOUNCE_CYCLES, 250000, stable-sample count for the debouncer (used only with BTN_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- left  in  1  browse-down button, level, synchronous to clk
- right  in  1  browse-up button, level
- select  in  1  commit button, level
- filter_mode  out  3  committed mode index
- cursor  out  3  currently browsed mode index
- busy  out  1  LCD write sequence in progress
- address  out  1  Avalon: 0 = instruction register, 1 = data register
- chipselect  out  1  Avalon chip select
- byteenable  out  1  Avalon byte enable, tied 1
- read  out  1  Avalon read, tied 0
- write  out  1  Avalon write
- waitrequest  in  1  Avalon slave stall
- readdata  in  8  unused
- response  in  2  unused
- writedata  out  8  Avalon write data

Behaviour:
- Reset (async assert, sync release) sets:
  - cursor = 0, filter_mode = 0, dirty = 1 (forces the power-up write).
  - FSM = IDLE; write = chipselect = address = writedata = 0; busy = 0.
  - Edge registers cleared.
- Edge detect: one registered copy per button; an event is `x & ~x_q`. Exactly one event per press.
- Cursor update (cycle after the event):
  - right only: cursor + 1. At N_MODES-1 it goes to 0 if WRAP=1, otherwise holds.
  - left only: cursor - 1. At 0 it goes to N_MODES-1 if WRAP=1, otherwise holds.
  - left and right in the same cycle: no change.
  - Any actual change sets dirty.
- Commit: a select event loads filter_mode <= cursor and sets dirty. Select in the same cycle as a move commits the pre-move cursor.
- Name ROM: 8 x 16 ASCII, NUL-terminated:
  - 0 "No Filter", 1 "Desaturate", 2 "Shift", 3 "Blur", 4 "Edge", 5 "Mode 5", 6 "Mode 6", 7 "Mode 7".
  - Only entries below N_MODES are reachable.
- Message sequence:
  - CLEAR_DISPLAY: address 0, data 0x01.
  - Then name characters, address 1, stopping at the first NUL or after MSG_LEN characters.
  - Then, if snapshot == filter_mode, a trailing '*' (0x2A), address 1.
- FSM states IDLE, ISSUE, GAP:
  - IDLE: if dirty, clear dirty, snapshot cursor, index = 0, go to ISSUE. busy = 0 only in IDLE with dirty = 0.
  - ISSUE: chipselect = write = 1, with address/writedata from the sequence. Hold all outputs stable while waitrequest = 1. The transfer is accepted in the cycle where waitrequest = 0.
  - On acceptance: go to GAP. If this was the last item, or dirty is set, the next state after GAP is IDLE; otherwise index + 1 and back to ISSUE.
  - GAP: one cycle with chipselect = write = 0 between transfers.
- Mid-sequence change: the in-flight transfer is never aborted. The remaining characters are dropped and the sequence restarts from CLEAR_DISPLAY via IDLE.
- Minimum sequence length with waitrequest = 0 is 1 + 2·items cycles from dirty to IDLE.
- Reset mid-transfer: outputs drop immediately. The slave must tolerate this; it is acceptable on this controller.

Optional Feature:
- Macro: BTN_DEBOUNCE_EN.
- Defined: each button passes a 2-flop synchroniser plus a counter. The filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples, and edge detection runs on the filtered level. This adds DEBOUNCE_CYCLES + 2 cycles of latency.
- Undefined: raw inputs feed edge detection directly, DEBOUNCE_CYCLES is ignored, and no counter logic is generated.

Test Plan:
- Release reset, waitrequest = 0 → transfers {0:0x01, 1:'N', 'o', ' ', 'F', 'i', 'l', 't', 'e', 'r', '*'}, then busy = 0; filter_mode = 0, cursor = 0.
- right pulse ×3 with sequences allowed to finish → cursor = 3, last message {0x01, 'B', 'l', 'u', 'r'} with no '*'. Then select → filter_mode = 3 and message {0x01, 'B', 'l', 'u', 'r', '*'}.
- WRAP = 1: left pulse from cursor = 0 → cursor = 4, name "Edge". WRAP = 0: left pulse at 0 → cursor stays 0 and no new sequence starts.
- Hold waitrequest = 1 for 10 cycles during the 'e' of "Desaturate" → write, address, writedata stable for all 10 cycles; exactly one transfer is accepted.
- right pulse during the 3rd character of a message → the current character completes, then the next transfer is 0x01 followed by the new name.
- left and right asserted in the same cycle → cursor unchanged and no new LCD sequence.
